// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared constants for the ALU issue stage:
//     - ALU operation-select codes driven onto the ALU's control input
//     - MIPS opcode and funct field values recognised by the decoder
//     - operand-B source selection enum
//     - default control-code width
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_CTRL_WIDTH = 4;

  // ALU operation-select codes. Values 10..15 are never produced.
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_NOR = 4'd4;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR = 4'd5;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL = 4'd6;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL = 4'd7;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_MUL = 4'd8;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = 4'd9;

  // Opcodes (Instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_SPEC2 = 6'h1C;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct values (Instr[5:0]) under OP_RTYPE
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // funct value under OP_SPEC2 selecting mul
  localparam logic [5:0] FN_MUL  = 6'h02;

  // Where operand B comes from. IMM_NONE forces B to zero (illegal decode).
  typedef enum logic [1:0] {
    IMM_REG  = 2'd0,
    IMM_SEXT = 2'd1,
    IMM_ZEXT = 2'd2,
    IMM_NONE = 2'd3
  } imm_sel_t;

endpackage : alu_pkg

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
//   Purely combinational MIPS instruction decoder for the ALU issue stage.
//   Ports:
//     opcode   in  6   Instr[31:26]
//     funct    in  6   Instr[5:0]
//     alu_ctrl out 4   ALU operation-select code (ALU_ADD when illegal)
//     imm_sel  out     operand-B source (register / sign-ext / zero-ext / none)
//     illegal  out 1   instruction not recognised
// -----------------------------------------------------------------------------
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0]                opcode,
  input  logic [5:0]                funct,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
  output imm_sel_t                  imm_sel,
  output logic                      illegal
);

  // R-type funct decode; kept separate so the opcode case stays readable.
  logic [ALU_CTRL_WIDTH-1:0] rtype_ctrl;
  logic                      rtype_ok;

  always_comb begin
    rtype_ctrl = ALU_ADD;
    rtype_ok   = 1'b1;
    case (funct)
      FN_ADD, FN_ADDU: rtype_ctrl = ALU_ADD;
      FN_SUB:          rtype_ctrl = ALU_SUB;
      FN_AND:          rtype_ctrl = ALU_AND;
      FN_OR:           rtype_ctrl = ALU_OR;
      FN_NOR:          rtype_ctrl = ALU_NOR;
      FN_XOR:          rtype_ctrl = ALU_XOR;
      FN_SLL:          rtype_ctrl = ALU_SLL;
      FN_SRL:          rtype_ctrl = ALU_SRL;
      FN_SLT:          rtype_ctrl = ALU_SLT;
      default:         rtype_ok   = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctrl = ALU_ADD;
    imm_sel  = IMM_REG;
    illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        alu_ctrl = rtype_ctrl;
        imm_sel  = IMM_REG;
        illegal  = ~rtype_ok;
      end
      OP_SPEC2: begin
        // Only mul is implemented in this opcode space.
        if (funct == FN_MUL) begin
          alu_ctrl = ALU_MUL;
          imm_sel  = IMM_REG;
        end else begin
          illegal  = 1'b1;
        end
      end
      // Address computation for loads/stores reuses the adder.
      OP_ADDI, OP_ADDIU,
      OP_LB, OP_LH, OP_LW,
      OP_SB, OP_SH, OP_SW: begin
        alu_ctrl = ALU_ADD;
        imm_sel  = IMM_SEXT;
      end
      OP_SLTI: begin
        alu_ctrl = ALU_SLT;
        imm_sel  = IMM_SEXT;
      end
      // Logical immediates are zero-extended, as in MIPS.
      OP_ANDI: begin
        alu_ctrl = ALU_AND;
        imm_sel  = IMM_ZEXT;
      end
      OP_ORI: begin
        alu_ctrl = ALU_OR;
        imm_sel  = IMM_ZEXT;
      end
      OP_XORI: begin
        alu_ctrl = ALU_XOR;
        imm_sel  = IMM_ZEXT;
      end
      // Branch compare: subtract rs - rt, zero flag decides.
      OP_BEQ, OP_BNE: begin
        alu_ctrl = ALU_SUB;
        imm_sel  = IMM_REG;
      end
      default: begin
        illegal  = 1'b1;
      end
    endcase

    // Undecodable instructions present a harmless add of A + 0.
    if (illegal) begin
      alu_ctrl = ALU_ADD;
      imm_sel  = IMM_NONE;
    end
  end

endmodule : alu_op_decode

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//   Registered ID/EX boundary in front of the 32-bit ALU. Decodes each MIPS
//   instruction and holds the ALU's control code and operands behind a
//   valid/ready handshake on both sides.
//   Ports:
//     Clk           in   1           clock, rising edge
//     Reset         in   1           synchronous active-high reset
//     Flush         in   1           drop held entry, block load this cycle
//     InValid       in   1           upstream has an instruction
//     InReady       out  1           stage can accept this cycle
//     Instr         in   32          instruction word
//     RsData        in   DATA_WIDTH  rs register value
//     RtData        in   DATA_WIDTH  rt register value
//     OutValid      out  1           ALU inputs valid
//     OutReady      in   1           downstream consumes this cycle
//     ALUControl    out  CTRL_WIDTH  operation-select code
//     A             out  DATA_WIDTH  operand A (rs)
//     B             out  DATA_WIDTH  operand B (rt or extended immediate)
//     Shamt         out  5           Instr[10:6]
//     IllegalOp     out  1           held entry was undecodable
//     IllegalCount  out  CNT_WIDTH   saturating count of accepted illegal ops
// -----------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = ALU_CTRL_WIDTH,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Flush,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [31:0]           Instr,
  input  logic [DATA_WIDTH-1:0] RsData,
  input  logic [DATA_WIDTH-1:0] RtData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [CTRL_WIDTH-1:0] ALUControl,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [4:0]            Shamt,
  output logic                  IllegalOp,
  output logic [CNT_WIDTH-1:0]  IllegalCount
);

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [ALU_CTRL_WIDTH-1:0] dec_ctrl;
  imm_sel_t                  dec_imm_sel;
  logic                      dec_illegal;

  alu_op_decode u_decode (
    .opcode   (Instr[31:26]),
    .funct    (Instr[5:0]),
    .alu_ctrl (dec_ctrl),
    .imm_sel  (dec_imm_sel),
    .illegal  (dec_illegal)
  );

  // Register-specifier fields are resolved by the register file upstream.
  logic unused_instr_bits;
  assign unused_instr_bits = ^Instr[25:16];

  // ---------------------------------------------------------------------------
  // Immediate extension
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] sext_imm;
  logic [DATA_WIDTH-1:0] zext_imm;

  assign sext_imm[15:0] = Instr[15:0];
  assign zext_imm[15:0] = Instr[15:0];

  genvar gi;
  generate
    for (gi = 16; gi < DATA_WIDTH; gi++) begin : g_ext
      assign sext_imm[gi] = Instr[15];
      assign zext_imm[gi] = 1'b0;
    end
  endgenerate

  logic [DATA_WIDTH-1:0] b_next;

  always_comb begin
    b_next = '0;
    case (dec_imm_sel)
      IMM_REG:  b_next = RtData;
      IMM_SEXT: b_next = sext_imm;
      IMM_ZEXT: b_next = zext_imm;
      default:  b_next = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic                  out_valid_reg;
  logic [CTRL_WIDTH-1:0] ctrl_reg;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic [4:0]            shamt_reg;
  logic                  illegal_reg;
  logic [CNT_WIDTH-1:0]  count_reg;
  logic                  load;

  // Ready does not look at Flush so upstream timing never depends on it;
  // Flush instead masks the load itself.
  assign InReady = ~out_valid_reg | OutReady;
  assign load    = InValid & InReady & ~Flush;

  // ---------------------------------------------------------------------------
  // Pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_reg <= 1'b0;
      ctrl_reg      <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      shamt_reg     <= '0;
      illegal_reg   <= 1'b0;
      count_reg     <= '0;
    end else begin
      if (Flush) begin
        out_valid_reg <= 1'b0;
      end else if (load) begin
        out_valid_reg <= 1'b1;
      end else if (OutReady) begin
        out_valid_reg <= 1'b0;
      end

      // Data fields only move on a load, so a stalled entry is frozen and
      // a drained entry leaves stale (but harmless) values behind.
      if (load) begin
        ctrl_reg    <= CTRL_WIDTH'(dec_ctrl);
        a_reg       <= RsData;
        b_reg       <= b_next;
        shamt_reg   <= Instr[10:6];
        illegal_reg <= dec_illegal;
        if (dec_illegal && (count_reg != '1)) begin
          count_reg <= count_reg + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign OutValid     = out_valid_reg;
  assign ALUControl   = ctrl_reg;
  assign A            = a_reg;
  assign B            = b_reg;
  assign Shamt        = shamt_reg;
  assign IllegalOp    = illegal_reg;
  assign IllegalCount = count_reg;

endmodule : alu_issue_stage

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//   Self-checking bench for alu_issue_stage: directed scenarios followed by
//   randomized traffic, all compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

  logic        Clk;
  logic        Reset;
  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [31:0] Instr;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic        OutValid;
  logic        OutReady;
  logic [3:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  Shamt;
  logic        IllegalOp;
  logic [7:0]  IllegalCount;

  alu_issue_stage dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Flush        (Flush),
    .InValid      (InValid),
    .InReady      (InReady),
    .Instr        (Instr),
    .RsData       (RsData),
    .RtData       (RtData),
    .OutValid     (OutValid),
    .OutReady     (OutReady),
    .ALUControl   (ALUControl),
    .A            (A),
    .B            (B),
    .Shamt        (Shamt),
    .IllegalOp    (IllegalOp),
    .IllegalCount (IllegalCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state: what the stage should be presenting.
  bit        m_known = 0;
  bit        m_valid;
  bit [3:0]  m_ctrl;
  bit [31:0] m_a, m_b;
  bit [4:0]  m_sh;
  bit        m_ill;
  int        m_cnt;

  // Instruction decode straight from the opcode/funct tables.
  function automatic void ref_decode(input bit [31:0] ins, input bit [31:0] rt,
                                     output bit [3:0] c, output bit [31:0] b,
                                     output bit ill);
    bit [5:0]  op = ins[31:26];
    bit [5:0]  fn = ins[5:0];
    bit [31:0] imm_u = {16'h0000, ins[15:0]};
    bit [31:0] imm_s = ins[15] ? (imm_u | 32'hFFFF0000) : imm_u;
    ill = 0;
    c   = 0;
    b   = rt;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: c = 0;
        6'h22: c = 1;
        6'h24: c = 2;
        6'h25: c = 3;
        6'h27: c = 4;
        6'h26: c = 5;
        6'h00: c = 6;
        6'h02: c = 7;
        6'h2A: c = 9;
        default: ill = 1;
      endcase
    end else begin
      case (op)
        6'h1C: if (fn == 6'h02) c = 8; else ill = 1;
        6'h08, 6'h09, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B: begin c = 0; b = imm_s; end
        6'h0A: begin c = 9; b = imm_s; end
        6'h0C: begin c = 2; b = imm_u; end
        6'h0D: begin c = 3; b = imm_u; end
        6'h0E: begin c = 5; b = imm_u; end
        6'h04, 6'h05: c = 1;
        default: ill = 1;
      endcase
    end
    if (ill) begin
      c = 0;
      b = 0;
    end
  endfunction

  // Apply one cycle of inputs, check at the negedge, advance the model at
  // the posedge, and return 1ns after the edge.
  task automatic cycle(input bit rst, input bit fl, input bit iv, input bit [31:0] ins,
                       input bit [31:0] rs, input bit [31:0] rt, input bit ordy);
    bit        acc;
    bit [3:0]  c;
    bit [31:0] b;
    bit        ill;
    Reset = rst; Flush = fl; InValid = iv; Instr = ins;
    RsData = rs; RtData = rt; OutReady = ordy;
    @(negedge Clk);
    if (m_known) begin
      chk("out_valid", {31'b0, OutValid}, {31'b0, m_valid});
      chk("in_ready", {31'b0, InReady}, {31'b0, (!m_valid || ordy)});
      chk("illegal_count", {24'b0, IllegalCount}, m_cnt);
      if (m_valid) begin
        chk("alu_control", {28'b0, ALUControl}, {28'b0, m_ctrl});
        chk("operand_a", A, m_a);
        chk("operand_b", B, m_b);
        chk("shamt", {27'b0, Shamt}, {27'b0, m_sh});
        chk("illegal_op", {31'b0, IllegalOp}, {31'b0, m_ill});
      end
    end
    @(posedge Clk);
    if (rst) begin
      m_known = 1; m_valid = 0; m_ctrl = 0; m_a = 0; m_b = 0;
      m_sh = 0; m_ill = 0; m_cnt = 0;
    end else if (m_known) begin
      acc = iv && (!m_valid || ordy) && !fl;
      if (acc) begin
        ref_decode(ins, rt, c, b, ill);
        m_ctrl = c; m_a = rs; m_b = b; m_sh = ins[10:6]; m_ill = ill;
        if (ill && m_cnt < 255) m_cnt++;
      end
      m_valid = fl ? 0 : (acc ? 1 : (ordy ? 0 : m_valid));
    end
    #1;
  endtask

  bit [5:0] rfun_list [0:10] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h27,
                                 6'h26, 6'h00, 6'h02, 6'h2A, 6'h03};
  bit [5:0] iop_list [0:15]  = '{6'h08, 6'h09, 6'h0A, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29,
                                 6'h2B, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h05, 6'h1C, 6'h0F};

  function automatic bit [31:0] rand_instr();
    bit [31:0] w = $urandom;
    case ($urandom_range(0, 3))
      0:       return w;
      1:       return {6'h00, w[25:6], rfun_list[$urandom_range(0, 10)]};
      2:       return {iop_list[$urandom_range(0, 15)], w[25:0]};
      default: return {6'h1C, w[25:6], ($urandom_range(0, 1) == 1) ? 6'h02 : w[5:0]};
    endcase
  endfunction

  initial begin
    Reset = 1; Flush = 0; InValid = 0; Instr = 0;
    RsData = 0; RtData = 0; OutReady = 0;

    // Reset held two cycles with a valid instruction offered.
    cycle(1, 0, 1, 32'h00221820, 5, 7, 1);
    cycle(1, 0, 1, 32'h00221820, 5, 7, 1);
    chk("rst_out_valid", {31'b0, OutValid}, 0);
    chk("rst_count", {24'b0, IllegalCount}, 0);
    chk("rst_ctrl", {28'b0, ALUControl}, 0);
    chk("rst_a", A, 0);
    chk("rst_b", B, 0);
    chk("rst_shamt", {27'b0, Shamt}, 0);
    chk("rst_illegal", {31'b0, IllegalOp}, 0);

    // add $3,$1,$2
    cycle(0, 0, 1, 32'h00221820, 5, 7, 1);
    chk("add_valid", {31'b0, OutValid}, 1);
    chk("add_ctrl", {28'b0, ALUControl}, 0);
    chk("add_a", A, 5);
    chk("add_b", B, 7);

    // andi zero-extends, addi sign-extends
    cycle(0, 0, 1, 32'h3022FFFF, 1, 2, 1);
    chk("andi_ctrl", {28'b0, ALUControl}, 2);
    chk("andi_b", B, 32'h0000FFFF);
    cycle(0, 0, 1, 32'h2022FFFF, 1, 2, 1);
    chk("addi_ctrl", {28'b0, ALUControl}, 0);
    chk("addi_b", B, 32'hFFFFFFFF);

    // sll shamt=4, then stall three cycles with a sub waiting
    cycle(0, 0, 1, 32'h00021100, 3, 32'hDEADBEEF, 1);
    chk("sll_ctrl", {28'b0, ALUControl}, 6);
    chk("sll_shamt", {27'b0, Shamt}, 4);
    chk("sll_b", B, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 32'h00221822, 9, 4, 0);
      chk("stall_in_ready", {31'b0, InReady}, 0);
      chk("stall_ctrl", {28'b0, ALUControl}, 6);
      chk("stall_shamt", {27'b0, Shamt}, 4);
      chk("stall_valid", {31'b0, OutValid}, 1);
    end
    cycle(0, 0, 1, 32'h00221822, 9, 4, 1);
    chk("release_ctrl", {28'b0, ALUControl}, 1);
    chk("release_a", A, 9);

    // Flush while holding a valid entry and offering a new one
    cycle(0, 1, 1, 32'h3022FFFF, 1, 2, 0);
    chk("flush_valid", {31'b0, OutValid}, 0);
    cycle(0, 1, 1, 32'hFC000000, 1, 2, 1);
    chk("flush_illegal_count", {24'b0, IllegalCount}, 0);
    chk("flush_valid2", {31'b0, OutValid}, 0);

    // 260 illegal instructions: counter saturates at 255
    for (int i = 0; i < 260; i++) begin
      cycle(0, 0, 1, 32'hFC000000 | ($urandom & 32'h03FFFFFF), $urandom, $urandom, 1);
      chk("illegal_op_flag", {31'b0, IllegalOp}, 1);
      chk("illegal_b_zero", B, 0);
    end
    chk("illegal_saturated", {24'b0, IllegalCount}, 255);

    // Randomized traffic
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom,
            ($urandom_range(0, 3) != 0));
    end
    cycle(0, 0, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_alu_issue_stage
